// File: rtl/qracc_csr_shadowed.sv
// ----------------------------------------------------------------------------
// qracc_csr_shadowed
//
// Double-buffered CSR bank for the QrAccelerator control path.
// Host writes go to shadow registers 1..NUM_CSR-1. The whole shadow set is
// copied into the active configuration only when a trigger is accepted, so
// the host can stage the next layer while the current layer runs.
// Register 0 (MAIN) holds command pulses, sticky W1C status, and RW controls.
//
// MAIN layout:
//   [2:0]  trigger code     (write-only pulse)
//   [3]    clear            (write-only pulse, also clears done/trig_err)
//   [4]    busy             (RO, live busy_i)
//   [5]    inst_write_mode  (write-only pulse)
//   [6]    done             (sticky, W1C)
//   [7]    trig_err         (sticky, W1C)
//   [11:8] internal_state   (RO, live internal_state_i)
//   [12]   preserve_ifmap   (RW)
//   [16]   irq_en           (RW)
//
// Ports:
//   clk, nrst                 clock, asynchronous active-low reset
//   bus_req_*                 single-port request (valid/wen/addr/data/be)
//   bus_resp_ready_o          always 1
//   bus_resp_rd_data_o/valid  read response, one cycle after the request
//   bus_resp_err_o            write error pulse, one cycle after the request
//   cfg_active_o              active regs 1..NUM_CSR-1, reg 1 at the LSBs
//   commit_o, trigger_o       pulses on an accepted trigger
//   clear_o, inst_write_mode_o command pulses
//   preserve_ifmap_o          MAIN[12]
//   busy_i, internal_state_i  controller status
//   irq_o                     irq_en & (done | trig_err), registered
// ----------------------------------------------------------------------------
module qracc_csr_shadowed #(
  parameter int          CSR_WIDTH     = 32,
  parameter int          NUM_CSR       = 16,
  parameter logic [31:0] CSR_BASE_ADDR = 32'h0000_0010,
  parameter int          IDX_W         = $clog2(NUM_CSR)
) (
  input  logic                               clk,
  input  logic                               nrst,
  input  logic                               bus_req_valid_i,
  input  logic                               bus_req_wen_i,
  input  logic [31:0]                        bus_req_addr_i,
  input  logic [CSR_WIDTH-1:0]               bus_req_data_i,
  input  logic [CSR_WIDTH/8-1:0]             bus_req_be_i,
  output logic                               bus_resp_ready_o,
  output logic [CSR_WIDTH-1:0]               bus_resp_rd_data_o,
  output logic                               bus_resp_rd_valid_o,
  output logic                               bus_resp_err_o,
  output logic [(NUM_CSR-1)*CSR_WIDTH-1:0]   cfg_active_o,
  output logic                               commit_o,
  output logic [2:0]                         trigger_o,
  output logic                               clear_o,
  output logic                               inst_write_mode_o,
  output logic                               preserve_ifmap_o,
  input  logic                               busy_i,
  input  logic [3:0]                         internal_state_i,
  output logic                               irq_o
);

  localparam int          NB       = CSR_WIDTH / 8;
  localparam logic [31:0] IDX_MASK = 32'(NUM_CSR - 1);

  // Packed arrays indexed [NUM_CSR-1:1]: reg 1 sits at the LSBs, which is
  // exactly the cfg_active_o layout.
  logic [NUM_CSR-1:1][CSR_WIDTH-1:0] shadow_q, shadow_d;
  logic [NUM_CSR-1:1][CSR_WIDTH-1:0] active_q, active_d;

  logic                 done_q, done_d;
  logic                 trig_err_q, trig_err_d;
  logic                 preserve_q, preserve_d;
  logic                 irq_en_q, irq_en_d;
  logic                 busy_prev_q, busy_prev_d;
  logic                 irq_q, irq_d;
  logic                 commit_q, commit_d;
  logic [2:0]           trigger_q, trigger_d;
  logic                 clear_q, clear_d;
  logic                 inst_wm_q, inst_wm_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [CSR_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                 err_q, err_d;

  logic                 hit;
  logic [IDX_W-1:0]     idx;
  logic                 is_main;
  logic                 wr_err;
  logic [CSR_WIDTH-1:0] main_rd;
  logic                 done_set, done_clr, trig_err_set, trig_err_clr;

  assign hit     = bus_req_valid_i && ((bus_req_addr_i & ~IDX_MASK) == CSR_BASE_ADDR);
  assign idx     = bus_req_addr_i[IDX_W-1:0];
  assign is_main = (idx == '0);

  // Byte 3 and above of MAIN hold only read-only bits, so a MAIN write that
  // enables none of bytes 0..2 cannot change anything and is flagged.
  assign wr_err = (bus_req_be_i == '0) || (is_main && (bus_req_be_i[2:0] == 3'b000));

  always_comb begin
    main_rd        = '0;
    main_rd[4]     = busy_i;
    main_rd[6]     = done_q;
    main_rd[7]     = trig_err_q;
    main_rd[11:8]  = internal_state_i;
    main_rd[12]    = preserve_q;
    main_rd[16]    = irq_en_q;
  end

  // NOTE: every combinational output gets a default at the top of the block,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    shadow_d     = shadow_q;
    active_d     = active_q;
    preserve_d   = preserve_q;
    irq_en_d     = irq_en_q;
    busy_prev_d  = busy_i;
    commit_d     = 1'b0;
    trigger_d    = 3'b000;
    clear_d      = 1'b0;
    inst_wm_d    = 1'b0;
    rd_valid_d   = 1'b0;
    rd_data_d    = '0;
    err_d        = 1'b0;
    done_clr     = 1'b0;
    trig_err_clr = 1'b0;
    trig_err_set = 1'b0;
    // done is raised on the falling edge of busy seen through its registered copy.
    done_set     = busy_prev_q & ~busy_i;

    if (hit) begin
      if (!bus_req_wen_i) begin
        rd_valid_d = 1'b1;
        if (is_main) begin
          rd_data_d = main_rd;
        end else begin
          for (int k = 1; k < NUM_CSR; k++) begin
            if (idx == IDX_W'(k)) rd_data_d = shadow_q[k];
          end
        end
      end else if (wr_err) begin
        err_d = 1'b1;
      end else if (is_main) begin
        if (bus_req_be_i[0]) begin
          if (bus_req_data_i[2:0] != 3'b000) begin
            if (!busy_i) begin
              trigger_d = bus_req_data_i[2:0];
              commit_d  = 1'b1;
              active_d  = shadow_q;
            end else begin
              trig_err_set = 1'b1;
            end
          end
          clear_d      = bus_req_data_i[3];
          inst_wm_d    = bus_req_data_i[5];
          done_clr     = bus_req_data_i[6] | bus_req_data_i[3];
          trig_err_clr = bus_req_data_i[7] | bus_req_data_i[3];
        end
        if (bus_req_be_i[1]) preserve_d = bus_req_data_i[12];
        if (bus_req_be_i[2]) irq_en_d   = bus_req_data_i[16];
      end else begin
        for (int k = 1; k < NUM_CSR; k++) begin
          if (idx == IDX_W'(k)) begin
            for (int b = 0; b < NB; b++) begin
              if (bus_req_be_i[b]) shadow_d[k][b*8 +: 8] = bus_req_data_i[b*8 +: 8];
            end
          end
        end
      end
    end

    // A set event in the same cycle as a clear wins.
    done_d     = done_set     | (done_q     & ~done_clr);
    trig_err_d = trig_err_set | (trig_err_q & ~trig_err_clr);
    irq_d      = irq_en_q & (done_q | trig_err_q);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  // NOTE: the shadow and active banks are reset along with the control flops
  // because software relies on reading zeros before the first write.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      shadow_q    <= '0;
      active_q    <= '0;
      done_q      <= 1'b0;
      trig_err_q  <= 1'b0;
      preserve_q  <= 1'b0;
      irq_en_q    <= 1'b0;
      busy_prev_q <= 1'b0;
      irq_q       <= 1'b0;
      commit_q    <= 1'b0;
      trigger_q   <= 3'b000;
      clear_q     <= 1'b0;
      inst_wm_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      done_q      <= done_d;
      trig_err_q  <= trig_err_d;
      preserve_q  <= preserve_d;
      irq_en_q    <= irq_en_d;
      busy_prev_q <= busy_prev_d;
      irq_q       <= irq_d;
      commit_q    <= commit_d;
      trigger_q   <= trigger_d;
      clear_q     <= clear_d;
      inst_wm_q   <= inst_wm_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      err_q       <= err_d;
    end
  end

  assign bus_resp_ready_o    = 1'b1;
  assign bus_resp_rd_data_o  = rd_data_q;
  assign bus_resp_rd_valid_o = rd_valid_q;
  assign bus_resp_err_o      = err_q;
  assign cfg_active_o        = active_q;
  assign commit_o            = commit_q;
  assign trigger_o           = trigger_q;
  assign clear_o             = clear_q;
  assign inst_write_mode_o   = inst_wm_q;
  assign preserve_ifmap_o    = preserve_q;
  assign irq_o               = irq_q;

endmodule

// File: tb/tb_qracc_csr_shadowed.sv
// ----------------------------------------------------------------------------
// tb_qracc_csr_shadowed
//
// Directed bench for qracc_csr_shadowed with default parameters.
// Inputs change on the falling clock edge; registered outputs are sampled on
// the following falling edge, i.e. one cycle after the request.
// ----------------------------------------------------------------------------
module tb_qracc_csr_shadowed;

  localparam int          W    = 32;
  localparam int          N    = 16;
  localparam logic [31:0] BASE = 32'h0000_0010;

  logic                 clk = 1'b0;
  logic                 nrst;
  logic                 bus_req_valid_i;
  logic                 bus_req_wen_i;
  logic [31:0]          bus_req_addr_i;
  logic [W-1:0]         bus_req_data_i;
  logic [W/8-1:0]       bus_req_be_i;
  logic                 bus_resp_ready_o;
  logic [W-1:0]         bus_resp_rd_data_o;
  logic                 bus_resp_rd_valid_o;
  logic                 bus_resp_err_o;
  logic [(N-1)*W-1:0]   cfg_active_o;
  logic                 commit_o;
  logic [2:0]           trigger_o;
  logic                 clear_o;
  logic                 inst_write_mode_o;
  logic                 preserve_ifmap_o;
  logic                 busy_i;
  logic [3:0]           internal_state_i;
  logic                 irq_o;

  int tests  = 0;
  int failed = 0;

  qracc_csr_shadowed dut (
    .clk                 (clk),
    .nrst                (nrst),
    .bus_req_valid_i     (bus_req_valid_i),
    .bus_req_wen_i       (bus_req_wen_i),
    .bus_req_addr_i      (bus_req_addr_i),
    .bus_req_data_i      (bus_req_data_i),
    .bus_req_be_i        (bus_req_be_i),
    .bus_resp_ready_o    (bus_resp_ready_o),
    .bus_resp_rd_data_o  (bus_resp_rd_data_o),
    .bus_resp_rd_valid_o (bus_resp_rd_valid_o),
    .bus_resp_err_o      (bus_resp_err_o),
    .cfg_active_o        (cfg_active_o),
    .commit_o            (commit_o),
    .trigger_o           (trigger_o),
    .clear_o             (clear_o),
    .inst_write_mode_o   (inst_write_mode_o),
    .preserve_ifmap_o    (preserve_ifmap_o),
    .busy_i              (busy_i),
    .internal_state_i    (internal_state_i),
    .irq_o               (irq_o)
  );

  always #5 clk = ~clk;

  // Watchdog: the directed sequence is a few hundred cycles at most.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] active_reg(input int k);
    return cfg_active_o[k*W-1 -: W];
  endfunction

  // Called at a falling edge; leaves the request up for one cycle and returns
  // at the next falling edge, where the response is visible.
  task automatic bus_wr(input logic [31:0] addr, input logic [W-1:0] data, input logic [3:0] be);
    bus_req_valid_i = 1'b1;
    bus_req_wen_i   = 1'b1;
    bus_req_addr_i  = addr;
    bus_req_data_i  = data;
    bus_req_be_i    = be;
    @(negedge clk);
    bus_req_valid_i = 1'b0;
    bus_req_wen_i   = 1'b0;
    bus_req_be_i    = '0;
  endtask

  task automatic bus_rd(input logic [31:0] addr);
    bus_req_valid_i = 1'b1;
    bus_req_wen_i   = 1'b0;
    bus_req_addr_i  = addr;
    bus_req_data_i  = '0;
    bus_req_be_i    = '0;
    @(negedge clk);
    bus_req_valid_i = 1'b0;
  endtask

  initial begin
    nrst             = 1'b0;
    bus_req_valid_i  = 1'b0;
    bus_req_wen_i    = 1'b0;
    bus_req_addr_i   = '0;
    bus_req_data_i   = '0;
    bus_req_be_i     = '0;
    busy_i           = 1'b0;
    internal_state_i = 4'h0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_ready",   W'(bus_resp_ready_o), 32'h1);
    check("rst_rdvalid", W'(bus_resp_rd_valid_o), 32'h0);
    check("rst_active2", active_reg(2), 32'h0);
    check("rst_pulses",  W'({commit_o, trigger_o, clear_o, inst_write_mode_o, irq_o, bus_resp_err_o}), 32'h0);
    nrst = 1'b1;
    @(negedge clk);
    check("post_rst_outs", W'({commit_o, trigger_o, clear_o, inst_write_mode_o, irq_o,
                               preserve_ifmap_o, bus_resp_err_o, bus_resp_rd_valid_o}), 32'h0);

    // Full-word shadow write, read back; active copy untouched
    bus_wr(BASE + 2, 32'h0040_0040, 4'hF);
    check("wr2_err",     W'(bus_resp_err_o), 32'h0);
    check("wr2_active",  active_reg(2), 32'h0);
    bus_rd(BASE + 2);
    check("rd2_valid",   W'(bus_resp_rd_valid_o), 32'h1);
    check("rd2_data",    bus_resp_rd_data_o, 32'h0040_0040);
    @(negedge clk);
    check("rd2_valid_lo", W'(bus_resp_rd_valid_o), 32'h0);
    check("rd2_data_lo",  bus_resp_rd_data_o, 32'h0);

    // Byte-enable merge
    bus_wr(BASE + 1, 32'h1234_5678, 4'hF);
    bus_wr(BASE + 1, 32'hFFFF_FFFF, 4'b0010);
    bus_rd(BASE + 1);
    check("rd1_be_merge", bus_resp_rd_data_o, 32'h1234_FF78);

    // Accepted trigger commits shadow to active
    busy_i = 1'b0;
    bus_wr(BASE, 32'h0000_0001, 4'b0001);
    check("trig_code",   W'(trigger_o), 32'h1);
    check("trig_commit", W'(commit_o), 32'h1);
    check("trig_act2",   active_reg(2), 32'h0040_0040);
    check("trig_act1",   active_reg(1), 32'h1234_FF78);
    @(negedge clk);
    check("trig_code_lo",   W'(trigger_o), 32'h0);
    check("trig_commit_lo", W'(commit_o), 32'h0);

    // Trigger while busy -> trig_err, irq one cycle later, W1C clears it
    bus_wr(BASE, 32'h0001_0000, 4'b0100);
    busy_i           = 1'b1;
    internal_state_i = 4'h5;
    bus_wr(BASE, 32'h0000_0002, 4'b0001);
    check("busy_trig_code",   W'(trigger_o), 32'h0);
    check("busy_trig_commit", W'(commit_o), 32'h0);
    check("busy_irq_early",   W'(irq_o), 32'h0);
    bus_rd(BASE);
    check("main_trig_err", bus_resp_rd_data_o, 32'h0001_0590);
    check("irq_rise",      W'(irq_o), 32'h1);
    bus_wr(BASE, 32'h0000_0080, 4'b0001);
    @(negedge clk);
    check("irq_fall",      W'(irq_o), 32'h0);

    // busy falling edge coincides with W1C of done: set wins
    busy_i = 1'b0;
    bus_wr(BASE, 32'h0000_0040, 4'b0001);
    bus_rd(BASE);
    check("done_set_wins", bus_resp_rd_data_o, 32'h0001_0540);
    check("done_irq",      W'(irq_o), 32'h1);
    bus_wr(BASE, 32'h0000_0040, 4'b0001);
    bus_rd(BASE);
    check("done_w1c",      bus_resp_rd_data_o, 32'h0001_0500);

    // Error responses, no state change
    bus_wr(BASE, 32'hFFFF_FFFF, 4'b1000);
    check("err_main_ro",   W'(bus_resp_err_o), 32'h1);
    bus_wr(BASE + 3, 32'hDEAD_BEEF, 4'b0000);
    check("err_be_zero",   W'(bus_resp_err_o), 32'h1);
    bus_rd(BASE);
    check("err_main_kept", bus_resp_rd_data_o, 32'h0001_0500);
    bus_rd(BASE + 3);
    check("err_reg3_kept", bus_resp_rd_data_o, 32'h0);

    // Command pulses and RW bit
    bus_wr(BASE, 32'h0000_0008, 4'b0001);
    check("clear_pulse",   W'(clear_o), 32'h1);
    @(negedge clk);
    check("clear_pulse_lo", W'(clear_o), 32'h0);
    bus_wr(BASE, 32'h0000_0020, 4'b0001);
    check("inst_wm_pulse", W'(inst_write_mode_o), 32'h1);
    bus_wr(BASE, 32'h0000_1000, 4'b0010);
    check("preserve_set",  W'(preserve_ifmap_o), 32'h1);

    // Address outside the window: no response
    bus_rd(32'h0000_0100);
    check("nohit_rdvalid", W'(bus_resp_rd_valid_o), 32'h0);

    // Reset asserted during a trigger write: nothing commits
    bus_wr(BASE + 2, 32'h0000_AAAA, 4'hF);
    busy_i          = 1'b0;
    bus_req_valid_i = 1'b1;
    bus_req_wen_i   = 1'b1;
    bus_req_addr_i  = BASE;
    bus_req_data_i  = 32'h0000_0001;
    bus_req_be_i    = 4'b0001;
    #2 nrst = 1'b0;
    #1;
    check("midrst_outs",  W'({commit_o, trigger_o, clear_o, inst_write_mode_o, irq_o,
                              preserve_ifmap_o, bus_resp_err_o, bus_resp_rd_valid_o}), 32'h0);
    check("midrst_act2",  active_reg(2), 32'h0);
    @(negedge clk);
    bus_req_valid_i = 1'b0;
    bus_req_wen_i   = 1'b0;
    bus_req_be_i    = '0;
    nrst            = 1'b1;
    @(negedge clk);
    check("after_rst_commit", W'({commit_o, trigger_o}), 32'h0);
    check("after_rst_act2",   active_reg(2), 32'h0);
    bus_rd(BASE + 2);
    check("after_rst_shadow2", bus_resp_rd_data_o, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
